// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset vector, program-end marker, NOP encoding and
// the instruction fetch state type.
package cpu_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_HALT_INSTR = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN,
        HALT_WAIT,
        HALTED
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {instruction, PC+4} entries.
// Flush empties the queue and takes priority over a push in the same cycle.
module fetch_queue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Pointer and occupancy bookkeeping; wraps modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= bump(wr_ptr);
            if (pop)  rd_ptr <= bump(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Entry storage; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues reads to the synchronous
// instruction RAM, queues returned words for decode, absorbs MEM-stage
// redirects and detects the program-end marker.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [31:0] HALT_INSTR = DEFAULT_HALT_INSTR,
    parameter int unsigned QDEPTH     = 2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pcplus4,
    output logic        halted
);

    localparam int unsigned CW = $clog2(QDEPTH + 1);

    fetch_state_t  state;
    fetch_state_t  state_nx;
    logic [31:0]   pc;
    logic [31:0]   req_pc;
    logic          inflight;
    logic          discard;
    logic [CW-1:0] q_count;
    logic [63:0]   q_head;
    logic          q_nonempty;
    logic          redirect_eff;
    logic          pop;
    logic          push;
    logic          flush;
    logic          halt_pop;
    logic          issue;
    int unsigned   occupancy;

    // Handshake, issue and queue control. imem_req is also gated by RESET_N so
    // it drops the instant reset asserts, not at the next edge.
    always_comb begin
        q_nonempty   = (q_count != '0);
        redirect_eff = redirect && (state != HALTED);
        id_valid     = q_nonempty && !redirect;
        pop          = id_valid && id_ready;
        push         = inflight && !discard && !redirect_eff;
        halt_pop     = pop && (state == HALT_WAIT) && (q_head[63:32] == HALT_INSTR);
        flush        = redirect_eff || halt_pop;
        occupancy    = 32'(q_count) + 32'(inflight) - 32'(pop);
        issue        = RESET_N && (state == RUN) && !redirect && (occupancy < QDEPTH);
        imem_req     = issue;
        imem_addr    = pc;
        id_instr     = q_nonempty ? q_head[63:32] : '0;
        id_pcplus4   = q_nonempty ? q_head[31:0]  : '0;
        halted       = (state == HALTED);
    end

    fetch_queue #(
        .DEPTH (QDEPTH),
        .WIDTH (64)
    ) u_queue (
        .clk   (CLK),
        .rst_n (RESET_N),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   ({imem_data, req_pc + 32'd4}),
        .head  (q_head),
        .count (q_count)
    );

    // Next state: a halt push parks fetch until the halt word is consumed;
    // a redirect cancels a pending (wrong-path) halt.
    always_comb begin
        state_nx = state;
        case (state)
            RUN:       if (push && (imem_data == HALT_INSTR)) state_nx = HALT_WAIT;
            HALT_WAIT: begin
                if (redirect_eff)  state_nx = RUN;
                else if (halt_pop) state_nx = HALTED;
            end
            HALTED:    state_nx = HALTED;
            default:   state_nx = RUN;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= RUN;
        else          state <= state_nx;
    end

    // PC, outstanding-request tracking and redirect discard flag.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pc       <= RESET_PC;
            req_pc   <= RESET_PC;
            inflight <= 1'b0;
            discard  <= 1'b0;
        end else begin
            if (redirect_eff)  pc <= redirect_pc & ~32'h3;
            else if (issue)    pc <= pc + 32'd4;
            if (issue)         req_pc <= pc;
            inflight <= issue;
            discard  <= redirect_eff && inflight;
        end
    end

endmodule
